// File: rtl/alu_pkg.sv
// Shared ALU op codes, MIPS opcode/funct constants and issue-controller types.
// Used by the ALU, the datapath control and the ALU issue controller.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b110;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    B_RT   = 2'd0,
    B_SEXT = 2'd1,
    B_ZEXT = 2'd2
  } b_sel_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS opcode/funct to ALU operation decoder.
// Also selects the B operand source and flags unsupported encodings.
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] op,
  output b_sel_t     b_sel,
  output logic       err
);

  logic rtype;
  assign rtype = (opcode == OPC_RTYPE);

  always_comb begin
    op    = ALU_ADD;
    b_sel = B_RT;
    err   = 1'b0;
    unique case (1'b1)
      rtype && (funct == FUNCT_ADD): op = ALU_ADD;
      rtype && (funct == FUNCT_SUB): op = ALU_SUB;
      rtype && (funct == FUNCT_AND): op = ALU_AND;
      rtype && (funct == FUNCT_OR):  op = ALU_OR;
      rtype && (funct == FUNCT_XOR): op = ALU_XOR;
      (opcode == OPC_ADDI): begin
        op    = ALU_ADD;
        b_sel = B_SEXT;
      end
      (opcode == OPC_ANDI): begin
        op    = ALU_AND;
        b_sel = B_ZEXT;
      end
      (opcode == OPC_ORI): begin
        op    = ALU_OR;
        b_sel = B_ZEXT;
      end
      (opcode == OPC_XORI): begin
        op    = ALU_XOR;
        b_sel = B_ZEXT;
      end
      (opcode == OPC_LUI): begin
        op    = ALU_LUI;
        b_sel = B_ZEXT;
      end
      (opcode == OPC_BEQ),
      (opcode == OPC_BNE): op = ALU_SUB;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: request handshake, operand registers, settle wait,
// and a held response channel back to the multi-cycle datapath control.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int EXEC_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [5:0]        req_funct,
  input  logic [DATA_W-1:0] req_rs,
  input  logic [DATA_W-1:0] req_rt,
  input  logic [15:0]       req_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  localparam logic [3:0] LAST = 4'(EXEC_CYC - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [2:0]        dec_op;
  b_sel_t            dec_b_sel;
  logic              dec_err;
  logic [DATA_W-1:0] b_val;

  alu_decode u_dec (
    .opcode (req_opcode),
    .funct  (req_funct),
    .op     (dec_op),
    .b_sel  (dec_b_sel),
    .err    (dec_err)
  );

  always_comb begin
    b_val = req_rt;
    unique case (dec_b_sel)
      B_SEXT:  b_val = DATA_W'($signed(req_imm));
      B_ZEXT:  b_val = DATA_W'(req_imm);
      default: b_val = req_rt;
    endcase
  end

  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= ALU_ADD;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (dec_err) begin
              // Rejected requests never touch the ALU operand registers.
              state      <= ST_RESP;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_zero   <= 1'b0;
            end else begin
              state  <= ST_EXEC;
              cnt    <= '0;
              alu_a  <= req_rs;
              alu_b  <= b_val;
              alu_op <= dec_op;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == LAST) begin
            state      <= ST_RESP;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the drive side.
// Vector table for decode/result paths plus backpressure and reset sequences.
module tb_alu_issue_ctrl;

  localparam int W  = 32;
  localparam int EC = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [5:0]   req_opcode = '0;
  logic [5:0]   req_funct = '0;
  logic [W-1:0] req_rs = '0;
  logic [W-1:0] req_rt = '0;
  logic [15:0]  req_imm = '0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_err;

  int errors = 0;
  int checks = 0;

  alu_issue_ctrl #(.DATA_W(W), .EXEC_CYC(EC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_funct  (req_funct),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_imm    (req_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b100:  alu_result = alu_a - alu_b;
      3'b001:  alu_result = alu_a & alu_b;
      3'b101:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a ^ alu_b;
      3'b110:  alu_result = {alu_b[15:0], 16'h0000};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic [5:0]   opc;
    logic [5:0]   fn;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [15:0]  imm;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] res;
    logic         z;
    logic         e;
  } vec_t;

  vec_t v[15];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t t, output int lat);
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_opcode = t.opc;
    req_funct  = t.fn;
    req_rs     = t.rs;
    req_rt     = t.rt;
    req_imm    = t.imm;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("req_ready_back", 64'(req_ready), 64'd1);
    rsp_ready = 1'b0;
  endtask

  int           lat;
  logic [W-1:0] last_a;
  logic [W-1:0] last_b;
  logic [2:0]   last_op;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0]  = '{6'h00, 6'b100000, 32'd5, 32'd7, 16'h0, 32'd7,
              3'b000, 32'd12, 1'b0, 1'b0};
    v[1]  = '{6'h00, 6'b100010, 32'd5, 32'd7, 16'h0, 32'd7,
              3'b100, 32'hFFFF_FFFE, 1'b0, 1'b0};
    v[2]  = '{6'h00, 6'b100100, 32'hF0F0, 32'hFF00, 16'h0, 32'hFF00,
              3'b001, 32'hF000, 1'b0, 1'b0};
    v[3]  = '{6'h00, 6'b100101, 32'hF0F0, 32'hFF00, 16'h0, 32'hFF00,
              3'b101, 32'hFFF0, 1'b0, 1'b0};
    v[4]  = '{6'h00, 6'b100110, 32'hF0F0, 32'hFF00, 16'h0, 32'hFF00,
              3'b010, 32'h0FF0, 1'b0, 1'b0};
    v[5]  = '{6'b000100, 6'b101010, 32'h1234, 32'h1234, 16'h0, 32'h1234,
              3'b100, 32'h0, 1'b1, 1'b0};
    v[6]  = '{6'b000101, 6'h00, 32'd3, 32'd2, 16'h0, 32'd2,
              3'b100, 32'd1, 1'b0, 1'b0};
    v[7]  = '{6'b001000, 6'h00, 32'd1, 32'h0, 16'hFFFF, 32'hFFFF_FFFF,
              3'b000, 32'h0, 1'b1, 1'b0};
    v[8]  = '{6'b001100, 6'h00, 32'hFFFF_FFFF, 32'h0, 16'h8001, 32'h8001,
              3'b001, 32'h8001, 1'b0, 1'b0};
    v[9]  = '{6'b001101, 6'h00, 32'h1234_0000, 32'h0, 16'h8000, 32'h8000,
              3'b101, 32'h1234_8000, 1'b0, 1'b0};
    v[10] = '{6'b001110, 6'h00, 32'hFFFF_0000, 32'h0, 16'hFFFF, 32'hFFFF,
              3'b010, 32'hFFFF_FFFF, 1'b0, 1'b0};
    v[11] = '{6'h00, 6'b101010, 32'd9, 32'd9, 16'h0, 32'h0,
              3'b000, 32'h0, 1'b0, 1'b1};
    v[12] = '{6'b100011, 6'h00, 32'd9, 32'd9, 16'h1, 32'h0,
              3'b000, 32'h0, 1'b0, 1'b1};
    v[13] = '{6'b001111, 6'h00, 32'h0, 32'h0, 16'hABCD, 32'hABCD,
              3'b110, 32'hABCD_0000, 1'b0, 1'b0};
    v[14] = '{6'b001000, 6'h00, 32'hFFFF_FFFF, 32'h0, 16'h0001, 32'h1,
              3'b000, 32'h0, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_zero", 64'(rsp_zero), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;

    last_a  = '0;
    last_b  = '0;
    last_op = 3'b000;
    for (int i = 0; i < 15; i++) begin
      issue(v[i], lat);
      chk($sformatf("v%0d_latency", i), 64'(lat),
          v[i].e ? 64'd1 : 64'(EC + 1));
      chk($sformatf("v%0d_result", i), 64'(rsp_result), 64'(v[i].res));
      chk($sformatf("v%0d_zero", i), 64'(rsp_zero), 64'(v[i].z));
      chk($sformatf("v%0d_err", i), 64'(rsp_err), 64'(v[i].e));
      chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'd0);
      if (!v[i].e) begin
        last_a  = v[i].rs;
        last_b  = v[i].b;
        last_op = v[i].op;
      end
      chk($sformatf("v%0d_alu_a", i), 64'(alu_a), 64'(last_a));
      chk($sformatf("v%0d_alu_b", i), 64'(alu_b), 64'(last_b));
      chk($sformatf("v%0d_alu_op", i), 64'(alu_op), 64'(last_op));
      drain();
    end

    // Backpressure: response must hold while a new request waits.
    issue(v[0], lat);
    chk("bp_latency", 64'(lat), 64'(EC + 1));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_opcode = v[1].opc;
      req_funct  = v[1].fn;
      req_rs     = 32'hDEAD;
      req_rt     = 32'hBEEF;
      @(posedge clk);
      #1;
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_result", 64'(rsp_result), 64'd12);
      chk("bp_rsp_zero", 64'(rsp_zero), 64'd0);
      chk("bp_rsp_err", 64'(rsp_err), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_alu_a", 64'(alu_a), 64'd5);
      chk("bp_alu_op", 64'(alu_op), 64'd0);
    end
    req_valid = 1'b0;
    drain();

    // Reset asserted while in EXEC.
    @(negedge clk);
    req_valid  = 1'b1;
    req_opcode = v[13].opc;
    req_funct  = v[13].fn;
    req_rs     = 32'h55;
    req_imm    = v[13].imm;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("exec_req_ready", 64'(req_ready), 64'd0);
    chk("exec_alu_op", 64'(alu_op), 64'b110);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_alu_a", 64'(alu_a), 64'd0);
    chk("arst_alu_b", 64'(alu_b), 64'd0);
    chk("arst_alu_op", 64'(alu_op), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(v[0], lat);
    chk("post_rst_latency", 64'(lat), 64'(EC + 1));
    chk("post_rst_result", 64'(rsp_result), 64'd12);

    // Reset asserted while a response is pending.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rresp_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rresp_rsp_result", 64'(rsp_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(v[11], lat);
    chk("post_rst_err_latency", 64'(lat), 64'd1);
    chk("post_rst_err", 64'(rsp_err), 64'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
